contour_bin_reader: RTL and testbench
=====================================

// Module: contour_bin_reader
// PURPOSE
//  Read-side companion to the contour tracer. Raster-scans a rectangular region of the
//  xy_bin BRAM (3-bit bin label per pixel, address = y*H_RES + x) and streams every
//  non-zero (contour) pixel out as an (x, y, bin) token with a valid/ready handshake.
//  Sits between the bin-map BRAM read port and downstream wing/overlay logic.
// PARAMETERS
//  H_RES     640  pixels per line; address stride per y step
//  READ_LAT  2    BRAM read latency in cycles (addr/en registered -> edge_in valid), >=1
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  start      in   1   one-cycle pulse; begins a scan when idle
//  x_min      in   10  region left column (inclusive), latched on start
//  x_max      in   10  region right column (inclusive)
//  y_min      in   9   region top row (inclusive)
//  y_max      in   9   region bottom row (inclusive)
//  addr       out  19  BRAM address
//  en         out  1   BRAM enable
//  we         out  1   BRAM write enable, constant 0
//  edge_in    in   3   BRAM read data (bin label, 0 = not contour)
//  pix_valid  out  1   output token valid
//  pix_ready  in   1   downstream accepts token
//  pix_x      out  10  token column
//  pix_y      out  9   token row
//  pix_bin    out  3   token bin label (never 0)
//  busy       out  1   scan in progress
//  done       out  1   one-cycle pulse at scan completion
// BEHAVIOUR
//  - Reset: all outputs 0 (addr, en, we, pix_*, busy, done); state IDLE. Asserting reset_n
//    low mid-scan aborts immediately; no done pulse; counters and bounds cleared.
//  - States: IDLE -> ISSUE -> WAIT -> CHECK -> (OUT) -> ISSUE ... -> FIN -> IDLE.
//  - IDLE: start=1 latches bounds, x=x_min, y=y_min, busy<=1. If x_min>x_max or
//    y_min>y_max: go to FIN (no BRAM read, en stays 0). start while busy is ignored.
//  - ISSUE: addr<=y*H_RES+x (19-bit unsigned, no wrap for in-range x/y), en<=1.
//  - WAIT: READ_LAT-1 cycles; en held 1, addr stable.
//  - CHECK: sample edge_in; en<=0. Non-zero -> load pix_x/y/bin, pix_valid<=1, go OUT.
//    Zero -> advance position.
//  - OUT: hold pix_* stable while pix_ready=0; scan stalls (addr unchanged, en=0).
//    On pix_valid&&pix_ready: pix_valid<=0 same edge, advance position.
//    pix_ready high while pix_valid low has no effect.
//  - Advance: x++ ; if x==x_max then x<=x_min, y++ ; if additionally y==y_max -> FIN,
//    else ISSUE. Zero-bin pixel period = READ_LAT+1 cycles; accepted token adds >=1 cycle.
//  - FIN: done<=1 for exactly one cycle, busy<=0, return IDLE. done never coincides with
//    pix_valid. start on the cycle done is high is ignored; accepted the next cycle.
//  - Out-of-range bounds (x>H_RES-1 or y>479) are not checked; caller guarantees range.
// CONFIGURATION
//  - BIN_HIST_EN defined: adds ports hist_sel in 3 and hist_count out 19; eight 19-bit
//    counters cleared on accepted start, counter[edge_in] incremented at each CHECK
//    (including bin 0); hist_count = counter[hist_sel], registered, 1-cycle latency;
//    values hold after done until next start; reset clears all to 0.
//  - Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. All-zero map, region (0,0)-(3,1), READ_LAT=2 -> addr 0,1,2,3,640,641,642,643; no
//     pix_valid; single done pulse; busy high start+1 to done.
//  2. Bin 5 at (2,1) only, pix_ready low 10 cycles -> pix_valid with x=2,y=1,bin=5 held
//     stable and addr frozen for 10 cycles; after ready, scan resumes at addr 643.
//  3. x_min=5,x_max=4 -> done one cycle after FIN entry, en never 1, pix_valid never 1.
//  4. start pulsed mid-scan -> ignored; reset_n low mid-scan -> all outputs 0 with no
//     clock; rescan after release produces full correct token sequence.
//  5. Region (639,479)-(639,479), bin 3 there -> addr 307199, one token (639,479,3), done.
//  6. BIN_HIST_EN, region (0,0)-(3,0), bins {2,2,7,2} -> hist_count sel2=3, sel7=1, sel0=0.

Source files
------------

// File: rtl/contour_bin_reader.sv
// Raster-scans a rectangle of the 3-bit bin-map BRAM and streams non-zero pixels as (x, y, bin) tokens.
// Optional per-bin histogram counters are compiled in when BIN_HIST_EN is defined.
module contour_bin_reader #(
    parameter int H_RES    = 640,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  x_min,
    input  logic [9:0]  x_max,
    input  logic [8:0]  y_min,
    input  logic [8:0]  y_max,
    output logic [18:0] addr,
    output logic        en,
    output logic        we,
    input  logic [2:0]  edge_in,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_bin,
    output logic        busy,
    output logic        done,
`ifdef BIN_HIST_EN
    input  logic [2:0]  hist_sel,
    output logic [18:0] hist_count,
`endif
    output logic [2:0]  dbg_state
);

    // Token handshake: a token transfers on any rising edge where pix_valid && pix_ready;
    // pix_x/pix_y/pix_bin stay stable from pix_valid rising until that transfer.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_OUT   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam int WAIT_W    = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam int WAIT_LAST = (READ_LAT > 2) ? (READ_LAT - 2) : 0;

    state_t              state_q;
    logic [9:0]          x_q, x_min_q, x_max_q;
    logic [8:0]          y_q, y_min_q, y_max_q;
    logic [18:0]         addr_q;
    logic                en_q;
    logic                pix_valid_q;
    logic [9:0]          pix_x_q;
    logic [8:0]          pix_y_q;
    logic [2:0]          pix_bin_q;
    logic                busy_q;
    logic                done_q;
    logic [WAIT_W-1:0]   wait_cnt_q;

    logic [9:0]          adv_x_d;
    logic [8:0]          adv_y_d;
    logic                adv_last_d;
    logic [18:0]         addr_d;
    logic                start_ok;

    always_comb begin
        adv_x_d    = x_q + 10'd1;
        adv_y_d    = y_q;
        adv_last_d = 1'b0;
        if (x_q == x_max_q) begin
            adv_x_d    = x_min_q;
            adv_y_d    = y_q + 9'd1;
            adv_last_d = (y_q == y_max_q);
        end
        addr_d = 19'(y_q) * 19'(H_RES) + 19'(x_q);
    end

    // A start arriving while done is still high is dropped so a caller cannot re-arm on the pulse.
    assign start_ok = (state_q == S_IDLE) && start && !done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_bin_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        x_min_q <= x_min;
                        x_max_q <= x_max;
                        y_min_q <= y_min;
                        y_max_q <= y_max;
                        x_q     <= x_min;
                        y_q     <= y_min;
                        busy_q  <= 1'b1;
                        if ((x_min > x_max) || (y_min > y_max)) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    addr_q     <= addr_d;
                    en_q       <= 1'b1;
                    wait_cnt_q <= '0;
                    if (READ_LAT == 1) begin
                        state_q <= S_CHECK;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_W'(WAIT_LAST)) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    en_q <= 1'b0;
                    if (edge_in != 3'd0) begin
                        pix_x_q     <= x_q;
                        pix_y_q     <= y_q;
                        pix_bin_q   <= edge_in;
                        pix_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        x_q <= adv_x_d;
                        y_q <= adv_y_d;
                        if (adv_last_d) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_OUT: begin
                    if (pix_ready) begin
                        pix_valid_q <= 1'b0;
                        x_q         <= adv_x_d;
                        y_q         <= adv_y_d;
                        if (adv_last_d) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addr      = addr_q;
    assign en        = en_q;
    assign we        = 1'b0;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_bin   = pix_bin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

`ifdef BIN_HIST_EN
    logic [18:0] hist_q [8];
    logic [18:0] hist_count_q;

    // Every sampled pixel is counted, bin 0 included, so the totals cover the whole region.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                hist_q[i] <= '0;
            end
            hist_count_q <= '0;
        end else begin
            if (start_ok) begin
                for (int i = 0; i < 8; i++) begin
                    hist_q[i] <= '0;
                end
            end else if (state_q == S_CHECK) begin
                hist_q[edge_in] <= hist_q[edge_in] + 19'd1;
            end
            hist_count_q <= hist_q[hist_sel];
        end
    end

    assign hist_count = hist_count_q;
`endif

endmodule

// File: tb/tb_contour_bin_reader.sv
// Self-checking bench for contour_bin_reader: table of scan regions plus hand-written
// stall, reset, start-collision and (with BIN_HIST_EN) histogram sequences.
module tb_contour_bin_reader;

    localparam int H = 640;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  x_min, x_max;
    logic [8:0]  y_min, y_max;
    logic [18:0] addr;
    logic        en, we;
    logic [2:0]  edge_in;
    logic        pix_valid, pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [2:0]  pix_bin;
    logic        busy, done;
    logic [2:0]  dbg_state;
`ifdef BIN_HIST_EN
    logic [2:0]  hist_sel;
    logic [18:0] hist_count;
`endif

    contour_bin_reader #(.H_RES(H), .READ_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .addr(addr), .en(en), .we(we), .edge_in(edge_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_bin(pix_bin),
        .busy(busy), .done(done),
`ifdef BIN_HIST_EN
        .hist_sel(hist_sel), .hist_count(hist_count),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one registered stage after the DUT's registered address gives READ_LAT=2
    logic [2:0] mem [0:307199];
    initial edge_in = 3'd0;
    always @(posedge clk) if (en) edge_in <= mem[addr];

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int x_min, x_max, y_min, y_max;
        int mid_start;
        int exp_reads, exp_tokens, exp_first, exp_last, exp_cycles;
    } vec_t;

    task automatic drive_bounds(input int a, input int b, input int c, input int d);
        x_min = 10'(a); x_max = 10'(b); y_min = 9'(c); y_max = 9'(d);
    endtask

    task automatic run_scan(input vec_t v, input string tag);
        int reads, tokens, cycles, first, last;
        logic prev_en;
        logic [21:0] tok, etok;
        exp_q.delete();
        for (int y = v.y_min; y <= v.y_max; y++)
            for (int x = v.x_min; x <= v.x_max; x++)
                if (mem[y*H+x] != 3'd0) exp_q.push_back({10'(x), 9'(y), mem[y*H+x]});
        @(negedge clk);
        drive_bounds(v.x_min, v.x_max, v.y_min, v.y_max);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        reads = 0; tokens = 0; cycles = 0; first = -1; last = -1;
        prev_en = en;
        while (!done && cycles < 2000) begin
            if (en && !prev_en) begin
                reads++;
                if (first < 0) first = int'(addr);
                last = int'(addr);
            end
            if (pix_valid && pix_ready) begin
                tok = {pix_x, pix_y, pix_bin};
                tokens++;
                etok = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check({tag, " token"}, 32'(tok), 32'(etok));
            end
            if (v.mid_start > 0 && cycles == v.mid_start) begin
                drive_bounds(0, 0, 0, 0);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            prev_en = en;
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " cycles_to_done"}, 32'(cycles), 32'(v.exp_cycles));
        check({tag, " reads"}, 32'(reads), 32'(v.exp_reads));
        check({tag, " tokens"}, 32'(tokens), 32'(v.exp_tokens));
        check({tag, " first_addr"}, 32'(first), 32'(v.exp_first));
        check({tag, " last_addr"}, 32'(last), 32'(v.exp_last));
        check({tag, " tokens_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, " valid_at_done"}, 32'(pix_valid), 32'd0);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic wait_cond_valid(input string tag, output bit ok);
        int n;
        n = 0;
        while (!pix_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = pix_valid;
        check({tag, " valid_seen"}, 32'(pix_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin
        bit ok;
        int bad, n, a0;
        vecs[0] = '{0, 3, 0, 1, 0, 8, 0, 0, 643, 25};
        vecs[1] = '{10, 12, 5, 6, 0, 6, 3, 3210, 3852, 22};
        vecs[2] = '{639, 639, 479, 479, 0, 1, 1, 307199, 307199, 5};
        vecs[3] = '{5, 4, 0, 0, 0, 0, 0, -1, -1, 1};
        vecs[4] = '{0, 0, 3, 2, 0, 0, 0, -1, -1, 1};
        vecs[5] = '{99, 101, 199, 200, 0, 6, 1, 127459, 128101, 20};
        vecs[6] = '{638, 639, 478, 479, 0, 4, 1, 306558, 307199, 14};
        vecs[7] = '{11, 11, 4, 6, 0, 3, 1, 2571, 3851, 11};
        vecs[8] = '{10, 12, 5, 6, 4, 6, 3, 3210, 3852, 22};

        for (int i = 0; i < 307200; i++) mem[i] = 3'd0;
        mem[5*H+10]   = 3'd1;
        mem[5*H+12]   = 3'd6;
        mem[6*H+11]   = 3'd7;
        mem[200*H+100] = 3'd4;
        mem[479*H+639] = 3'd3;

        reset_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
        drive_bounds(0, 0, 0, 0);
`ifdef BIN_HIST_EN
        hist_sel = 3'd0;
`endif
        #3;
        check("reset_outputs", {addr, en, we, pix_valid, pix_x, pix_y, pix_bin, busy, done},
              32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

        // token held under back-pressure, scan frozen
        mem[1*H+2] = 3'd5;
        pix_ready = 1'b0;
        @(negedge clk);
        drive_bounds(0, 3, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cond_valid("stall", ok);
        check("stall token", 32'({pix_x, pix_y, pix_bin}), 32'({10'd2, 9'd1, 3'd5}));
        check("stall addr", 32'(addr), 32'd642);
        a0 = int'(addr);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!pix_valid || pix_x != 10'd2 || pix_y != 9'd1 || pix_bin != 3'd5 ||
                int'(addr) != a0 || en) bad++;
        end
        check("stall hold_bad_cycles", 32'(bad), 32'd0);
        pix_ready = 1'b1;
        @(negedge clk);
        check("stall valid_dropped", 32'(pix_valid), 32'd0);
        n = 0;
        while (!en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall resume_addr", 32'(addr), 32'd643);
        wait_done("stall");
        mem[1*H+2] = 3'd0;

        // asynchronous reset mid-scan, then full rescan
        @(negedge clk);
        drive_bounds(10, 12, 5, 6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {addr, en, we, pix_valid, pix_x, pix_y, pix_bin, busy, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_scan(vecs[1], "rescan");

        // start while done is high is dropped, accepted one cycle later
        @(negedge clk);
        drive_bounds(5, 4, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("collide done_high", 32'(done), 32'd1);
        drive_bounds(0, 0, 0, 0);
        start = 1'b1;
        @(negedge clk);
        check("collide start_ignored", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("collide start_accepted", 32'(busy), 32'd1);
        wait_done("collide");

`ifdef BIN_HIST_EN
        mem[0] = 3'd2; mem[1] = 3'd2; mem[2] = 3'd7; mem[3] = 3'd2;
        run_scan('{0, 3, 0, 0, 0, 4, 4, 0, 3, 17}, "hist");
        hist_sel = 3'd2;
        @(negedge clk); @(negedge clk);
        check("hist sel2", 32'(hist_count), 32'd3);
        hist_sel = 3'd7;
        @(negedge clk); @(negedge clk);
        check("hist sel7", 32'(hist_count), 32'd1);
        hist_sel = 3'd0;
        @(negedge clk); @(negedge clk);
        check("hist sel0", 32'(hist_count), 32'd0);
        for (int i = 0; i < 4; i++) mem[i] = 3'd0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
